mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, watchdog limit in cycles; range 1..65535; used only with MEM_ARB_TIMEOUT_EN.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- if_req, in, 1, instruction-fetch request.
- if_addr, in, ADDR_W, fetch address.
- if_rdata, out, DATA_W, fetch read data.
- if_ready, out, 1, fetch completion pulse.
- dm_req, in, 1, data-memory request.
- dm_we, in, 1, data write enable.
- dm_addr, in, ADDR_W, data address.
- dm_wdata, in, DATA_W, data write value.
- dm_rdata, out, DATA_W, data read value.
- dm_ready, out, 1, data completion pulse.
- mem_en, out, 1, memory transaction active.
- mem_we, out, 1, memory write.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- mem_ack, in, 1, memory completion, one cycle.
- stall_if, out, 1, fetch stage stall to the hazard unit.
- stall_mem, out, 1, memory stage stall to the hazard unit.
- err, out, 1, sticky timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, IFETCH, DATA; the only legal transitions are IDLE->IFETCH, IDLE->DATA, IFETCH->IDLE, DATA->IDLE.
REQ-004 IDLE arbitration SHALL follow these rules:
- dm_req only -> DATA.
- if_req only -> IFETCH.
- Both asserted -> DATA, unless last_grant==DATA, in which case IFETCH (anti-starvation).
REQ-005 On a grant SHALL register mem_addr, mem_we (dm_we on DATA, 0 on IFETCH), mem_wdata; mem_en SHALL be 1 from the cycle after the grant decision until the completion cycle inclusive.
REQ-006 Registered mem_* outputs SHALL be held constant for the whole transaction, independent of requester input changes.
REQ-007 On mem_ack in IFETCH, SHALL drive if_ready=1 and if_rdata=mem_rdata combinationally in the same cycle, then return to IDLE.
REQ-008 On mem_ack in DATA, SHALL drive dm_ready=1 and dm_rdata=mem_rdata combinationally in the same cycle, then return to IDLE.
REQ-009 Minimum latency SHALL be 2 cycles from req sampled in IDLE to the ready pulse; there SHALL be exactly one IDLE cycle between consecutive transactions.
REQ-010 mem_ack SHALL be ignored in IDLE.
REQ-011 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and ready still pulses.
REQ-012 last_grant SHALL update on every grant and reset to IFETCH.
REQ-013 Stall outputs SHALL be combinational: stall_if = if_req & ~if_ready; stall_mem = dm_req & ~dm_ready.
REQ-014 if_rdata and dm_rdata SHALL be 0 when the corresponding ready is 0.

Reset
REQ-015 While rst_n is low, SHALL force:
- state=IDLE.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- last_grant=IFETCH, err=0, watchdog counter=0.
REQ-016 Reset asserted mid-transaction SHALL abort it immediately with no ready pulse; the first grant can occur in the first clock edge after release.

Configuration
REQ-017 With MEM_ARB_TIMEOUT_EN defined, a watchdog SHALL:
- count busy cycles.
- If TIMEOUT cycles elapse without mem_ack, end the transaction.
- Pulse the owner's ready with rdata=ERR_DATA (0xDEADBEEF).
- Set err=1 until reset.
- Return to IDLE.
REQ-018 Without MEM_ARB_TIMEOUT_EN, SHALL contain no watchdog logic, tie err to 0, and wait for mem_ack indefinitely.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the FSM state enum, the grant-owner enum (IFETCH/DATA), and the ERR_DATA constant.
REQ-020 The watchdog SHALL be sub-module mem_arb_timer (inputs clear and busy; output expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-021 Bench SHALL cover these directed scenarios, one line each:
- Fetch, ack 3 cycles later: if_req=1, if_addr=0x100 -> mem_en=1, mem_addr=0x100, mem_we=0 next cycle; if_ready with mem_rdata=0x2402000A on the ack cycle; stall_if=1 until then.
- Contention: if_req=1, dm_req=1, dm_we=1, dm_addr=0x2000, dm_wdata=0x55 -> DATA first (mem_we=1, mem_wdata=0x55), then IFETCH next; if_req remaining high never starves.
- Back-to-back data with if_req high: second grant goes to IFETCH per last_grant; exactly one IDLE cycle between transactions.
- Mid-transaction reset: rst_n=0 while DATA busy -> mem_en=0 immediately; no dm_ready; a fresh grant occurs after release.
- Timeout with macro, TIMEOUT=4, no ack -> after 4 busy cycles dm_ready=1, dm_rdata=0xDEADBEEF, err=1 sticky.
- Without macro, no ack for 1000 cycles -> still busy; err=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the memory arbiter.
//   state_t : arbiter FSM states (IDLE / IFETCH / DATA)
//   owner_t : grant owner, remembered for anti-starvation
//   ERR_DATA: read data returned on a watchdog timeout
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFETCH = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFETCH = 1'b0,
        OWN_DATA   = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer -- busy-cycle watchdog for mem_arbiter.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count (transaction finished)
//   busy       : a transaction is outstanding this cycle
//   expired    : this busy cycle is the TIMEOUT-th without completion
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    // cnt holds the number of busy cycles already elapsed, so the
    // TIMEOUT-th busy cycle sees cnt == TIMEOUT-1.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (busy)
            cnt <= cnt + 16'd1;
    end

    assign expired = busy & (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a fetch port and a data port onto one memory
// port. One transaction at a time; data wins contention unless it won the
// previous grant. Optional watchdog with `define MEM_ARB_TIMEOUT_EN.
//   clk, rst_n                      : clock, async active-low reset
//   if_req/if_addr                  : fetch request in
//   if_rdata/if_ready               : fetch completion (ready is a pulse)
//   dm_req/dm_we/dm_addr/dm_wdata   : data request in
//   dm_rdata/dm_ready               : data completion (ready is a pulse)
//   mem_en/mem_we/mem_addr/mem_wdata: registered memory request
//   mem_rdata/mem_ack               : memory response
//   stall_if/stall_mem              : hazard-unit stalls
//   err                             : sticky watchdog timeout flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    state_t      state;
    owner_t      last_grant;
    logic        busy;
    logic        expired;
    logic        done;
    logic        dm_wins;
    logic [DATA_W-1:0] rdata_sel;

    assign busy = (state != S_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (done),
        .busy    (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (expired)
            err <= 1'b1;
    end
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    // mem_ack outside a transaction is ignored because busy gates it.
    assign done = busy & (mem_ack | expired);

    // A real ack always takes precedence over the timeout error word.
    assign rdata_sel = mem_ack ? mem_rdata : DATA_W'(ERR_DATA);

    assign if_ready = (state == S_IFETCH) & done;
    assign dm_ready = (state == S_DATA)   & done;
    assign if_rdata = if_ready ? rdata_sel : '0;
    assign dm_rdata = dm_ready ? rdata_sel : '0;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    // Data wins contention unless it also won the previous grant.
    assign dm_wins = dm_req & (~if_req | (last_grant == OWN_IFETCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= OWN_IFETCH;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dm_wins) begin
                        state      <= S_DATA;
                        last_grant <= OWN_DATA;
                        mem_en     <= 1'b1;
                        mem_we     <= dm_we;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                    end else if (if_req) begin
                        state      <= S_IFETCH;
                        last_grant <= OWN_IFETCH;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                    end
                end
                S_IFETCH, S_DATA: begin
                    // Request drops are ignored; only completion ends it.
                    if (done) begin
                        state  <= S_IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          stall_if;
    logic          stall_mem;
    logic          err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data),
    // what was captured at grant, who won last (0 fetch, 1 data),
    // busy cycles elapsed, and the sticky error.
    int          m_own = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_we = 1'b0;
    int          m_last = 0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit hit, fin, ifr, dmr;
        logic [31:0] rd;
        if (!rst_n) begin
            m_own = 0; m_we = 1'b0; m_last = 0; m_cnt = 0; m_err = 1'b0;
            m_addr = '0; m_wdata = '0;
            chk("rst mem_en", 32'(mem_en), 32'd0);
            chk("rst mem_we", 32'(mem_we), 32'd0);
            chk("rst mem_addr", mem_addr, 32'd0);
            chk("rst mem_wdata", mem_wdata, 32'd0);
            chk("rst err", 32'(err), 32'd0);
            chk("rst if_ready", 32'(if_ready), 32'd0);
            chk("rst dm_ready", 32'(dm_ready), 32'd0);
            return;
        end
        hit = TO_EN && (m_own != 0) && (m_cnt + 1 == TO);
        fin = (m_own != 0) && (mem_ack || hit);
        ifr = fin && (m_own == 1);
        dmr = fin && (m_own == 2);
        rd  = mem_ack ? mem_rdata : 32'hDEADBEEF;
        chk("mem_en", 32'(mem_en), 32'(m_own != 0));
        chk("mem_we", 32'(mem_we), 32'((m_own == 2) && m_we));
        if (m_own != 0) chk("mem_addr", mem_addr, m_addr);
        if (m_own == 2) chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_ready", 32'(if_ready), 32'(ifr));
        chk("if_rdata", if_rdata, ifr ? rd : 32'd0);
        chk("dm_ready", 32'(dm_ready), 32'(dmr));
        chk("dm_rdata", dm_rdata, dmr ? rd : 32'd0);
        chk("stall_if", 32'(stall_if), 32'(if_req && !ifr));
        chk("stall_mem", 32'(stall_mem), 32'(dm_req && !dmr));
        chk("err", 32'(err), 32'(m_err));
        // what the coming clock edge does
        if (m_own == 0) begin
            if (dm_req && (!if_req || m_last == 0)) begin
                m_own = 2; m_last = 1; m_addr = dm_addr; m_we = dm_we;
                m_wdata = dm_wdata; m_cnt = 0;
            end else if (if_req) begin
                m_own = 1; m_last = 0; m_addr = if_addr; m_we = 1'b0; m_cnt = 0;
            end
        end else if (fin) begin
            m_own = 0; m_cnt = 0;
            if (hit) m_err = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are checked on the
    // falling edge, then the model advances to match the next rising edge.
    task automatic tick();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        // reset
        repeat (2) begin tick(); adv(); end
        rst_n = 1'b1;

        // ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick();
        chk("idle ack if_ready", 32'(if_ready), 32'd0);
        chk("idle ack dm_ready", 32'(dm_ready), 32'd0);
        adv();
        mem_ack = 1'b0;

        // fetch, ack on the third busy cycle
        if_req = 1'b1; if_addr = 32'h100;
        tick(); adv();
        tick();
        chk("f mem_en", 32'(mem_en), 32'd1);
        chk("f mem_addr", mem_addr, 32'h100);
        chk("f mem_we", 32'(mem_we), 32'd0);
        chk("f stall_if", 32'(stall_if), 32'd1);
        adv();
        tick(); adv();
        mem_ack = 1'b1; mem_rdata = 32'h2402000A;
        tick();
        chk("f if_ready", 32'(if_ready), 32'd1);
        chk("f if_rdata", if_rdata, 32'h2402000A);
        chk("f stall_if done", 32'(stall_if), 32'd0);
        adv();
        quiet();
        tick(); chk("f idle", 32'(mem_en), 32'd0); adv();

        // contention: data first, then fetch
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h55;
        tick(); adv();
        mem_ack = 1'b1; mem_rdata = 32'h11;
        tick();
        chk("c mem_addr", mem_addr, 32'h2000);
        chk("c mem_we", 32'(mem_we), 32'd1);
        chk("c mem_wdata", mem_wdata, 32'h55);
        chk("c dm_ready", 32'(dm_ready), 32'd1);
        chk("c stall_if", 32'(stall_if), 32'd1);
        adv();
        mem_ack = 1'b0;
        tick(); chk("c gap", 32'(mem_en), 32'd0); adv();
        mem_ack = 1'b1; mem_rdata = 32'h22;
        tick();
        chk("c f mem_addr", mem_addr, 32'h104);
        chk("c f mem_we", 32'(mem_we), 32'd0);
        chk("c f if_ready", 32'(if_ready), 32'd1);
        adv();
        quiet();
        tick(); adv();

        // back-to-back with both requests held and ack every busy cycle
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; mem_ack = 1'b1; mem_rdata = 32'h33;
        tick(); chk("b2b idle0", 32'(mem_en), 32'd0); adv();
        tick(); chk("b2b data", 32'(dm_ready), 32'd1); adv();
        tick(); chk("b2b gap", 32'(mem_en), 32'd0); adv();
        tick(); chk("b2b fetch", 32'(if_ready), 32'd1);
        chk("b2b fetch addr", mem_addr, 32'h200); adv();
        tick(); chk("b2b gap2", 32'(mem_en), 32'd0); adv();
        tick(); chk("b2b data2", 32'(dm_ready), 32'd1); adv();
        quiet();
        tick(); adv();

        // reset in the middle of a data transaction
        dm_req = 1'b1; dm_addr = 32'h300;
        tick(); adv();
        tick(); chk("r busy", 32'(mem_en), 32'd1); adv();
        rst_n = 1'b0;
        #1;
        chk("r mem_en now", 32'(mem_en), 32'd0);
        chk("r mem_addr now", mem_addr, 32'd0);
        mem_ack = 1'b1;
        tick(); chk("r no dm_ready", 32'(dm_ready), 32'd0); adv();
        rst_n = 1'b1; mem_ack = 1'b0;
        tick(); adv();
        mem_ack = 1'b1;
        tick();
        chk("r regrant", 32'(mem_en), 32'd1);
        chk("r regrant addr", mem_addr, 32'h300);
        adv();
        quiet();
        tick(); adv();

`ifdef MEM_ARB_TIMEOUT_EN
        // watchdog: no ack, fourth busy cycle ends it with the error word
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        tick(); adv();
        repeat (3) begin
            tick(); chk("t waiting", 32'(dm_ready), 32'd0); adv();
        end
        tick();
        chk("t dm_ready", 32'(dm_ready), 32'd1);
        chk("t dm_rdata", dm_rdata, 32'hDEADBEEF);
        adv();
        quiet();
        tick(); chk("t err set", 32'(err), 32'd1); chk("t idle", 32'(mem_en), 32'd0); adv();
        if_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h44;
        tick(); adv();
        tick(); chk("t normal", if_rdata, 32'h44); adv();
        quiet();
        tick(); chk("t err sticky", 32'(err), 32'd1); adv();
`else
        // no watchdog: a transaction waits forever for its ack
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h66;
        tick(); adv();
        repeat (1000) begin tick(); adv(); end
        tick();
        chk("nt still busy", 32'(mem_en), 32'd1);
        chk("nt stall_mem", 32'(stall_mem), 32'd1);
        chk("nt err", 32'(err), 32'd0);
        adv();
        mem_ack = 1'b1;
        tick(); chk("nt finally", 32'(dm_ready), 32'd1); adv();
        quiet();
        tick(); adv();
`endif

        // randomized traffic, including requester drops and rare resets
        for (int i = 0; i < 3000; i++) begin
            if_req    = ($urandom_range(0, 2) != 0);
            dm_req    = ($urandom_range(0, 2) != 0);
            dm_we     = $urandom_range(0, 1) == 1;
            if_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            mem_rdata = $urandom;
            mem_ack   = ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            tick(); adv();
        end
        rst_n = 1'b1;
        quiet();
        tick(); adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
